// File: rtl/serial_add_8bit_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master side presents operands and consumes results; the slave side is the adder.
interface serial_add_8bit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout
    );
endinterface

// File: rtl/serial_add_8bit.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// It computes S = (A + B + Cin) mod 2^WIDTH and Cout = carry out of the MSB.
// Used beside the serial subtractor to recover the minuend from D and B.
// The result register S only changes on the final bit, so consumers never see
// partial sums.
module serial_add_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_8bit_if.slave     bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Single-bit full adder; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic sum_v;
        logic carry_v;
        sum_v   = a ^ b ^ c;
        carry_v = (a & b) | (c & (a ^ b));
        return {carry_v, sum_v};
    endfunction

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic             c_q,         c_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] s_q,         s_d;
    logic             cout_q,      cout_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       fa_s;
    logic [WIDTH-1:0] res_next_s;

    // Full-adder cell on the current LSBs and the shifted-in result word.
    always_comb begin
        fa_s       = full_add(a_q[0], b_q[0], c_q);
        res_next_s = {fa_s[0], res_q[WIDTH-1:1]};
    end

    // Next-state and next-output computation for the handshake/shift sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.A;
                    b_d        = bus.B;
                    c_d        = bus.Cin;
                    res_d      = {WIDTH{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d = res_next_s;
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = fa_s[1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the whole word and the final carry together.
                    s_d         = res_next_s;
                    cout_d      = fa_s[1];
                    out_valid_d = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            c_q         <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            s_q         <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
endmodule
